// File: rtl/sel_sequencer.sv
// Stimulus sequencer for the select-decode block: walks the 2**WIDTH select space in
// up/gray/down/LFSR order over a valid/ready handshake. Define SEL_SEQ_LFSR_EN for LFSR mode 11.
module sel_sequencer #(
    parameter int               WIDTH     = 3,
    parameter int               REPEAT    = 1,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 'b110
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       mode_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sel_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       sweep_o
);
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [WIDTH:0] FULL_LEN = (WIDTH+1)'(1) << WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [1:0]     mode_q;
    logic [WIDTH:0] idx;
    logic [RW-1:0]  rep;
    logic           hs;
    logic           last_vec;
    logic [WIDTH:0] sweep_len;
    logic [WIDTH:0] idx_nxt;

    function automatic logic [WIDTH-1:0] first_vec(input logic [1:0] m);
        case (m)
            2'b10:   first_vec = '1;
`ifdef SEL_SEQ_LFSR_EN
            2'b11:   first_vec = WIDTH'(1);
`endif
            default: first_vec = '0;
        endcase
    endfunction

    // idx counts accepted vectors in the sweep; the vector itself is derived from it,
    // except for LFSR which steps from the current sel_o.
    function automatic logic [WIDTH-1:0] next_vec(input logic [1:0] m, input logic [WIDTH:0] k,
                                                  input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] kw;
        kw = k[WIDTH-1:0];
        case (m)
            2'b01:   next_vec = kw ^ (kw >> 1);
            2'b10:   next_vec = ~kw;
`ifdef SEL_SEQ_LFSR_EN
            2'b11:   next_vec = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
`endif
            default: next_vec = kw;
        endcase
        if (m == 2'b11 && cur == '1 && 1'b0) next_vec = '0;
    endfunction

`ifdef SEL_SEQ_LFSR_EN
    assign sweep_len = (mode_q == 2'b11) ? FULL_LEN - 1'b1 : FULL_LEN;
`else
    assign sweep_len = FULL_LEN;
    // Taps only matter when the LFSR is built in.
    logic taps_unused;
    assign taps_unused = ^LFSR_TAPS;
`endif

    assign hs       = valid_o & ready_i;
    assign idx_nxt  = idx + 1'b1;
    assign last_vec = (idx_nxt == sweep_len);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            mode_q  <= 2'b00;
            idx     <= '0;
            rep     <= '0;
            sel_o   <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            sweep_o <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state   <= RUN;
                        mode_q  <= mode_i;
                        idx     <= '0;
                        rep     <= '0;
                        sel_o   <= first_vec(mode_i);
                        valid_o <= 1'b1;
                        busy_o  <= 1'b1;
                        sweep_o <= 8'd0;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else if (hs) begin
                        if (last_vec) begin
                            if (sweep_o != 8'hFF) sweep_o <= sweep_o + 8'd1;
                            idx   <= '0;
                            sel_o <= first_vec(mode_q);
                            if (rep == RW'(REPEAT - 1)) begin
                                state   <= DONE;
                                valid_o <= 1'b0;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                            end else begin
                                rep <= rep + 1'b1;
                            end
                        end else begin
                            idx   <= idx_nxt;
                            sel_o <= next_vec(mode_q, idx_nxt, sel_o);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule
